// File: rtl/fetch_queue.sv
// In-order {pc, instruction} buffer between the I-cache and decode.
// Redirect flush discards every queued wrong-path entry and anything arriving with it.
module fetch_queue #(
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_flush,
  input  logic                  i_valid,
  input  logic [ADDR_WIDTH-1:0] i_pc,
  input  logic [DATA_WIDTH-1:0] i_inst,
  output logic                  o_ready,
  input  logic                  i_stall,
  output logic                  o_valid,
  output logic [ADDR_WIDTH-1:0] o_pc,
  output logic [DATA_WIDTH-1:0] o_inst,
  output logic [CW-1:0]         o_count,
  output logic                  o_overflow
);

  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] inst;
  } entry_t;

  entry_t        mem [DEPTH];
  logic [PW-1:0] rd_q, rd_d;
  logic [PW-1:0] wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic          push, pop;

  // Handshake flags depend only on registered count, never on i_valid/i_stall.
  assign o_ready = (cnt_q != FULL);
  assign o_valid = (cnt_q != '0);
  assign o_count = cnt_q;
  assign o_overflow = ovf_q;

  assign push = i_valid & o_ready & ~i_flush;
  assign pop  = o_valid & ~i_stall & ~i_flush;

  assign o_pc   = o_valid ? mem[rd_q].pc   : '0;
  assign o_inst = o_valid ? mem[rd_q].inst : '0;

  always_comb begin
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q | (i_valid & ~o_ready & ~i_flush);
    if (i_flush) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      // Power-of-two depth: natural pointer overflow is the modulo wrap.
      if (push) wr_d = wr_q + PW'(1);
      if (pop)  rd_d = rd_q + PW'(1);
      cnt_d = cnt_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  // Storage is not reset; o_valid masks stale contents.
  always_ff @(posedge clk) begin
    if (push) mem[wr_q] <= '{pc: i_pc, inst: i_inst};
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed plus random test of fetch_queue against a queue-based reference model.
module tb_fetch_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_flush, i_valid, i_stall;
  logic [31:0] i_pc, i_inst;
  logic        o_ready, o_valid, o_overflow;
  logic [31:0] o_pc, o_inst;
  logic [2:0]  o_count;

  int total = 0;
  int bad   = 0;

  logic [31:0] m_pc[$];
  logic [31:0] m_inst[$];
  logic        m_ovf;

  fetch_queue #(.DEPTH(DEPTH), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .i_flush(i_flush), .i_valid(i_valid),
    .i_pc(i_pc), .i_inst(i_inst), .o_ready(o_ready), .i_stall(i_stall),
    .o_valid(o_valid), .o_pc(o_pc), .o_inst(o_inst), .o_count(o_count),
    .o_overflow(o_overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    int n = m_pc.size();
    chk({tag, ".valid"}, 64'(o_valid),    64'(n != 0));
    chk({tag, ".ready"}, 64'(o_ready),    64'(n != DEPTH));
    chk({tag, ".count"}, 64'(o_count),    64'(n));
    chk({tag, ".pc"},    64'(o_pc),       (n != 0) ? 64'(m_pc[0])   : 64'd0);
    chk({tag, ".inst"},  64'(o_inst),     (n != 0) ? 64'(m_inst[0]) : 64'd0);
    chk({tag, ".ovf"},   64'(o_overflow), 64'(m_ovf));
  endtask

  // Reference behaviour from the pre-edge model state.
  task automatic model(input logic v, input logic [31:0] pc, input logic [31:0] in,
                       input logic st, input logic fl);
    bit full  = (m_pc.size() == DEPTH);
    bit avail = (m_pc.size() != 0);
    if (v && full && !fl) m_ovf = 1'b1;
    if (fl) begin
      m_pc.delete();
      m_inst.delete();
    end else begin
      if (avail && !st) begin
        void'(m_pc.pop_front());
        void'(m_inst.pop_front());
      end
      if (v && !full) begin
        m_pc.push_back(pc);
        m_inst.push_back(in);
      end
    end
  endtask

  task automatic step(input string tag, input logic v, input logic [31:0] pc,
                      input logic [31:0] in, input logic st, input logic fl);
    i_valid = v; i_pc = pc; i_inst = in; i_stall = st; i_flush = fl;
    @(posedge clk);
    model(v, pc, in, st, fl);
    #1;
    check_all(tag);
  endtask

  initial begin
    logic [31:0] prev_pc;
    logic [31:0] npc;
    int          peak;
    logic [31:0] tinst [3];
    tinst[0] = 32'h20080001; tinst[1] = 32'h20090002; tinst[2] = 32'h01095020;

    rst_n = 1'b0; i_flush = 0; i_valid = 0; i_stall = 0; i_pc = '0; i_inst = '0;
    m_ovf = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    rst_n = 1'b1;

    // Three back-to-back pushes with decode consuming every cycle.
    peak = 0;
    for (int k = 0; k < 3; k++) begin
      step("seq", 1'b1, 32'(4 * k), tinst[k], 1'b0, 1'b0);
      if (int'(o_count) > peak) peak = int'(o_count);
    end
    step("seq_tail", 1'b0, '0, '0, 1'b0, 1'b0);
    chk("seq_peak", 64'(peak), 64'd1);

    // Stall-fill to full, overflow attempt, then drain.
    for (int k = 0; k < 4; k++) step("fill", 1'b1, 32'h100 + 32'(4 * k), 32'hA000 + 32'(k), 1'b1, 1'b0);
    chk("full_pc_held", 64'(o_pc), 64'h100);
    step("ovf_push", 1'b1, 32'h110, 32'hBAD, 1'b1, 1'b0);
    chk("ovf_set", 64'(o_overflow), 64'd1);
    chk("ovf_cnt", 64'(o_count), 64'd4);
    for (int k = 0; k < 4; k++) begin
      chk("drain_pc", 64'(o_pc), 64'h100 + 64'(4 * k));
      step("drain", 1'b0, '0, '0, 1'b0, 1'b0);
    end

    // Hold 3 entries, then steady push+pop across the pointer wrap.
    npc = 32'h300;
    for (int k = 0; k < 3; k++) begin
      step("fill3", 1'b1, npc, ~npc, 1'b1, 1'b0);
      npc += 4;
    end
    prev_pc = o_pc;
    for (int k = 0; k < 10; k++) begin
      step("wrap", 1'b1, npc, ~npc, 1'b0, 1'b0);
      npc += 4;
      chk("wrap_cnt", 64'(o_count), 64'd3);
      chk("wrap_inc", 64'(o_pc), 64'(prev_pc + 32'd4));
      prev_pc = o_pc;
    end

    // Flush with a concurrent wrong-path push.
    step("flush", 1'b1, 32'h200, 32'h1234, 1'b0, 1'b1);
    chk("flush_valid", 64'(o_valid), 64'd0);
    chk("flush_pc", 64'(o_pc), 64'd0);
    step("post_flush", 1'b1, 32'h400, 32'h5678, 1'b0, 1'b0);
    chk("post_flush_pc", 64'(o_pc), 64'h400);
    step("post_flush2", 1'b0, '0, '0, 1'b0, 1'b0);
    step("flush_empty", 1'b0, '0, '0, 1'b0, 1'b1);

    // Asynchronous reset between edges with live entries and sticky overflow.
    step("pre_rst", 1'b1, 32'h500, 32'h1, 1'b1, 1'b0);
    step("pre_rst", 1'b1, 32'h504, 32'h2, 1'b1, 1'b0);
    chk("pre_rst_ovf", 64'(o_overflow), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    m_pc.delete(); m_inst.delete(); m_ovf = 1'b0;
    check_all("async_rst");
    #1;
    rst_n = 1'b1;

    // Random traffic.
    for (int k = 0; k < 400; k++) begin
      step("rand", 1'($urandom_range(0, 9) < 7), $urandom, $urandom,
           1'($urandom_range(0, 9) < 4), 1'($urandom_range(0, 19) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    bad++;
    $display("FAIL timeout observed=running expected=finished");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
